// File: rtl/myproject_mac_pipe_16s_17s.sv
// Pipelined signed MAC: din0*din1 through NUM_STAGE product registers, accumulated per in_last frame,
// then arithmetic-shifted and saturated into dout. Define MAC_ROUND_NEAREST_EN to round half up before the shift.
module myproject_mac_pipe_16s_17s #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 17,
  parameter int ACC_WIDTH  = 40,
  parameter int dout_WIDTH = 29,
  parameter int NUM_STAGE  = 2,
  parameter int SHIFT      = 0
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic                         out_sat
);

  localparam int PW = din0_WIDTH + din1_WIDTH;
  // One guard bit so the rounding add and the saturation compare never wrap.
  localparam int EW = ACC_WIDTH + 1;

  localparam logic signed [EW-1:0] SAT_MAX = {{(EW-dout_WIDTH+1){1'b0}}, {(dout_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;

`ifdef MAC_ROUND_NEAREST_EN
  localparam logic signed [EW-1:0] RND = (EW'(1) << SHIFT) >> 1;
`else
  localparam logic signed [EW-1:0] RND = '0;
`endif

  if (ID < 0) begin : g_chk_id
    $error("instance tag must be non-negative");
  end
  if (ACC_WIDTH < PW) begin : g_chk_acc
    $error("ACC_WIDTH must hold the full-precision product");
  end
  if (dout_WIDTH < 2 || dout_WIDTH > ACC_WIDTH) begin : g_chk_dout
    $error("dout_WIDTH must be in 2..ACC_WIDTH");
  end
  if (NUM_STAGE < 1 || NUM_STAGE > 4) begin : g_chk_stage
    $error("NUM_STAGE must be in 1..4");
  end
  if (SHIFT < 0 || SHIFT >= ACC_WIDTH) begin : g_chk_shift
    $error("SHIFT must be in 0..ACC_WIDTH-1");
  end

  logic signed [PW-1:0]         prod_q [NUM_STAGE];
  logic [NUM_STAGE-1:0]         pvld_q;
  logic [NUM_STAGE-1:0]         plast_q;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                         first_q, first_d;
  logic                         out_valid_q, out_valid_d;
  logic signed [dout_WIDTH-1:0] dout_q, dout_d;
  logic                         out_sat_q, out_sat_d;

  logic                         adv;
  logic signed [PW-1:0]         prod_in;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  acc_sum;
  logic signed [EW-1:0]         pre_shift;
  logic signed [EW-1:0]         shifted;
  logic                         tail_vld;
  logic                         tail_last;

  // A pending, unconsumed result freezes the whole datapath.
  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;

  assign prod_in   = PW'(din0) * PW'(din1);
  assign tail_vld  = pvld_q[NUM_STAGE-1];
  assign tail_last = plast_q[NUM_STAGE-1];
  assign prod_ext  = ACC_WIDTH'(prod_q[NUM_STAGE-1]);
  assign acc_sum   = first_q ? prod_ext : acc_q + prod_ext;
  assign pre_shift = EW'(acc_sum) + RND;
  assign shifted   = pre_shift >>> SHIFT;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_STAGE; i++) begin
        prod_q[i] <= '0;
      end
      pvld_q  <= '0;
      plast_q <= '0;
    end else if (adv) begin
      prod_q[0]  <= prod_in;
      pvld_q[0]  <= in_valid;
      plast_q[0] <= in_valid && in_last;
      for (int i = 1; i < NUM_STAGE; i++) begin
        prod_q[i]  <= prod_q[i-1];
        pvld_q[i]  <= pvld_q[i-1];
        plast_q[i] <= plast_q[i-1];
      end
    end
  end

  always_comb begin
    acc_d       = acc_q;
    first_d     = first_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    out_sat_d   = out_sat_q;
    if (adv) begin
      out_valid_d = tail_vld && tail_last;
      if (tail_vld) begin
        acc_d   = acc_sum;
        first_d = tail_last;
      end
      if (tail_vld && tail_last) begin
        if (shifted > SAT_MAX) begin
          dout_d    = SAT_MAX[dout_WIDTH-1:0];
          out_sat_d = 1'b1;
        end else if (shifted < SAT_MIN) begin
          dout_d    = SAT_MIN[dout_WIDTH-1:0];
          out_sat_d = 1'b1;
        end else begin
          dout_d    = shifted[dout_WIDTH-1:0];
          out_sat_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q       <= '0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_myproject_mac_pipe_16s_17s.sv
// Bench for myproject_mac_pipe_16s_17s: frame-level model with a negedge compare process,
// plus literal expectations for each directed scenario.
module tb_myproject_mac_pipe_16s_17s;

  localparam int AW = 40;
  localparam int DW = 29;
`ifdef MAC_ROUND_NEAREST_EN
  localparam bit     RND_EN  = 1'b1;
  localparam longint B_EXPECT = -1;
`else
  localparam bit     RND_EN  = 1'b0;
  localparam longint B_EXPECT = -2;
`endif

  logic ap_clk = 1'b0;
  logic ap_rst_n;
  always #5 ap_clk = ~ap_clk;

  logic               in_valid, in_ready, in_last, out_valid, out_ready, out_sat;
  logic signed [15:0] din0;
  logic signed [16:0] din1;
  logic signed [28:0] dout;

  logic               b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_sat;
  logic signed [15:0] b_din0;
  logic signed [16:0] b_din1;
  logic signed [28:0] b_dout;

  myproject_mac_pipe_16s_17s dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .din0(din0), .din1(din1), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .out_sat(out_sat)
  );

  myproject_mac_pipe_16s_17s #(.SHIFT(4)) dut_b (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .din0(b_din0), .din1(b_din1), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .dout(b_dout), .out_sat(b_out_sat)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct { longint d; bit s; } res_t;

  res_t   exp_q[$];
  longint hist[$];
  bit     hist_sat[$];
  longint m_sum;
  bit     m_first = 1'b1;
  longint held;

  function automatic longint wrap_acc(input longint v);
    return (v <<< (64 - AW)) >>> (64 - AW);
  endfunction

  // Frame result: optional half-up rounding, floor shift, clip to DW signed bits.
  function automatic res_t scale_sat(input longint acc, input int sh);
    longint hi, lo, r;
    res_t o;
    hi = (longint'(1) <<< (DW - 1)) - 1;
    lo = -hi - 1;
    r  = acc;
    if (RND_EN && sh > 0) r = r + (longint'(1) <<< (sh - 1));
    r   = r >>> sh;
    o.s = (r > hi) || (r < lo);
    o.d = (r > hi) ? hi : ((r < lo) ? lo : r);
    return o;
  endfunction

  // Model update on accepted beats and comparison of every presented result.
  always @(negedge ap_clk) begin
    longint p;
    if (!ap_rst_n) begin
      m_sum   = 0;
      m_first = 1'b1;
      exp_q.delete();
      check("out_valid_in_reset", out_valid, 0);
    end else begin
      if (in_valid && in_ready) begin
        p       = longint'(din0) * longint'(din1);
        m_sum   = m_first ? p : wrap_acc(m_sum + p);
        m_first = in_last;
        if (in_last) exp_q.push_back(scale_sat(m_sum, 0));
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          check("dout", dout, exp_q[0].d);
          check("out_sat", out_sat, exp_q[0].s);
          if (out_ready) begin
            hist.push_back(dout);
            hist_sat.push_back(out_sat);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // Called and returns at posedge+1; holds the beat until it is accepted.
  task automatic send(input int a, input int b, input bit last);
    int budget = 0;
    bit took;
    din0     = 16'(a);
    din1     = 17'(b);
    in_last  = last;
    in_valid = 1'b1;
    do begin
      @(negedge ap_clk);
      took = in_ready;
      @(posedge ap_clk);
      budget++;
    end while (!took && budget < 200);
    if (!took) check("send_timeout", 0, 1);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(posedge ap_clk);
      budget++;
    end
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic wait_out_valid();
    int budget = 0;
    while (!out_valid && budget < 50) begin
      @(negedge ap_clk);
      budget++;
    end
    check("bp_result_seen", out_valid, 1);
  endtask

  function automatic longint hist_back(input int k);
    if (hist.size() <= k) return 64'h7fff_ffff_ffff_ffff;
    return hist[hist.size() - 1 - k];
  endfunction

  function automatic longint sat_back(input int k);
    if (hist_sat.size() <= k) return -1;
    return longint'(hist_sat[hist_sat.size() - 1 - k]);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    ap_rst_n    = 1'b0;
    in_valid    = 1'b0; in_last = 1'b0; din0 = '0; din1 = '0; out_ready = 1'b1;
    b_in_valid  = 1'b0; b_in_last = 1'b0; b_din0 = '0; b_din1 = '0; b_out_ready = 1'b1;
    repeat (2) @(posedge ap_clk);
    #3 ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;

    check("rst_out_valid", out_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_in_ready", in_ready, 1);

    check("pin_model_pos_sat", scale_sat(2147385345, 0).d, 268435455);
    check("pin_model_neg_sat", scale_sat(-2147450880, 0).d, -268435456);

    // Single beat: latency of NUM_STAGE+1 cycles.
    send(3, -5, 1);
    check("lat_cycle1", out_valid, 0);
    @(posedge ap_clk); #1;
    check("lat_cycle2", out_valid, 0);
    @(posedge ap_clk); #1;
    check("lat_cycle3", out_valid, 1);
    drain();
    check("single_dout", hist_back(0), -15);
    check("single_sat", sat_back(0), 0);

    // Four-beat frame then a single-beat frame, back to back.
    send(100, 200, 0);
    send(-50, 300, 0);
    send(7, -7, 0);
    send(1, 1, 1);
    send(2, 3, 1);
    drain();
    check("frame4_dout", hist_back(1), 4952);
    check("frame_after_dout", hist_back(0), 6);

    // Saturation in both directions.
    send(32767, 65535, 1);
    send(-32768, 65535, 1);
    drain();
    check("sat_pos_dout", hist_back(1), 268435455);
    check("sat_pos_flag", sat_back(1), 1);
    check("sat_neg_dout", hist_back(0), -268435456);
    check("sat_neg_flag", sat_back(0), 1);

    // Backpressure: hold the result for several cycles while beats are still arriving.
    out_ready = 1'b0;
    fork
      begin
        send(10, 10, 1);
        send(1, 2, 0);
        send(3, 4, 1);
        send(5, 6, 1);
      end
      begin
        wait_out_valid();
        held = dout;
        repeat (5) begin
          @(negedge ap_clk);
          check("bp_in_ready", in_ready, 0);
          check("bp_dout_hold", dout, held);
        end
        @(posedge ap_clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_first", hist_back(2), 100);
    check("bp_second", hist_back(1), 14);
    check("bp_third", hist_back(0), 30);

    // Asynchronous reset in the middle of a frame.
    send(5, 5, 0);
    send(5, 5, 0);
    #1 ap_rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_dout", dout, 0);
    repeat (2) @(posedge ap_clk);
    #3 ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    check("post_rst_in_ready", in_ready, 1);
    send(2, 3, 1);
    drain();
    check("post_rst_dout", hist_back(0), 6);

    // Shifted instance: product -17 >>> 4.
    b_din0 = -16'sd17; b_din1 = 17'sd1; b_in_last = 1'b1; b_in_valid = 1'b1;
    @(posedge ap_clk); #1;
    b_in_valid = 1'b0; b_in_last = 1'b0;
    budget = 0;
    while (!b_out_valid && budget < 20) begin
      @(posedge ap_clk); #1;
      budget++;
    end
    check("shift_out_valid", b_out_valid, 1);
    check("shift_dout", b_dout, B_EXPECT);
    check("shift_dout_model", b_dout, scale_sat(-17, 4).d);
    check("shift_sat", b_out_sat, 0);

    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/myproject_mac_pipe_16s_17s.md
Name: myproject_mac_pipe_16s_17s

Overview:
Parametrised, pipelined signed multiply-accumulate unit. It is the successor to the combinational 16s x 17s multiplier primitive used in the pruned CNN datapath.
- Streams (din0, din1) pairs through a NUM_STAGE-deep multiplier pipeline into an accumulator.
- Emits one scaled, saturated dot-product result per in_last-terminated frame.
- Sits between the weight/activation streams and the layer output buffer.

Parameters:
ID, 1, instance tag (no behavioural effect)
din0_WIDTH, 16, signed activation width
din1_WIDTH, 17, signed weight width
ACC_WIDTH, 40, signed accumulator width; must be >= din0_WIDTH+din1_WIDTH
dout_WIDTH, 29, signed output width; must be <= ACC_WIDTH
NUM_STAGE, 2, product pipeline registers, legal range 1..4
SHIFT, 0, arithmetic right shift applied to the accumulator before saturation, 0..ACC_WIDTH-1

Ports:
ap_clk  in  1  clock, rising edge
ap_rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input pair valid
in_ready  out  1  unit can accept a pair
din0  in  din0_WIDTH  signed operand A
din1  in  din1_WIDTH  signed operand B
in_last  in  1  final pair of the current frame
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
dout  out  dout_WIDTH  signed result
out_sat  out  1  result was clipped

Behaviour:
- Clocking and reset:
  - Single clock, ap_clk.
  - Reset is asynchronous, active-low: ap_rst_n.
  - Reset clears all pipeline valid bits, the accumulator, the first-beat flag (set to 1), out_valid=0, dout=0, out_sat=0.
  - in_ready is 1 immediately after reset.
- Handshake:
  - An input beat is accepted when in_valid && in_ready.
  - Global advance enable is adv = !out_valid || out_ready.
  - in_ready = adv. When adv=0, every pipeline register, valid bit and the accumulator hold.
- Product pipeline:
  - Full-precision signed product, width din0_WIDTH+din1_WIDTH, sign-extended to ACC_WIDTH.
  - The product is registered through NUM_STAGE stages. Each stage carries valid and last bits.
- Accumulator stage (on adv with a valid product arriving):
  - If first=1: acc = product. Otherwise acc = acc + product, two's-complement, wrapping at ACC_WIDTH.
  - first is then updated to the arriving last bit.
- Output:
  - On the arriving last: compute r = (acc_next >>> SHIFT), with arithmetic shift (floor).
  - Saturate r to [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1].
  - Register r into dout, set out_valid=1, and set out_sat=1 if clipping occurred, else 0.
- out_valid behaviour:
  - out_valid clears on out_ready unless a new result loads in the same cycle.
  - Simultaneous consume and new load: the new result replaces the old and out_valid stays 1.
  - dout and out_sat are stable while out_valid && !out_ready.
- Latency: a last beat accepted at cycle t gives out_valid=1 at t+NUM_STAGE+1, assuming no stall.
- Back-to-back frames are supported with no bubble. Single-beat frames (in_last on the first beat) are legal.
- Reset mid-frame discards the partial sum; the next accepted beat starts a new frame.

Optional Feature:
MAC_ROUND_NEAREST_EN
- Defined and SHIFT>0: add 2^(SHIFT-1) to acc_next before the shift (round half toward +inf). Saturation is checked after rounding.
- Undefined, or SHIFT=0: plain floor shift.

Test Plan:
- Defaults, single beat din0=3, din1=-5, in_last=1 at cycle t -> dout=-15, out_sat=0, out_valid rises at t+3.
- 4-beat frame (100,200), (-50,300), (7,-7), (1,1), last on beat 4 -> dout=4952; immediately followed by single-beat frame (2,3) -> dout=6 with no stale sum.
- Saturation: single beat 32767 x 65535 -> dout=268435455, out_sat=1; single beat -32768 x 65535 -> dout=-268435456, out_sat=1.
- Backpressure: result pending, out_ready held low 5 cycles -> in_ready=0 for those cycles, dout unchanged, no input lost; in-flight beats complete after release.
- Reset mid-frame: two beats (5,5), (5,5) accepted, ap_rst_n pulsed low asynchronously, then frame (2,3, last) -> dout=6, out_valid low throughout reset.
- SHIFT=4, product -17 -> dout=-2 without the macro; dout=-1 with MAC_ROUND_NEAREST_EN.
